// File: rtl/decode_pkg.sv
// Shared opcode constants, format/queue encodings and ctrl field layout for the
// wide decode stage.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {RT, IT, ST, BT, UT, JT} imm_src_t;

  typedef enum logic [1:0] {
    Q_NONE = 2'b00,
    Q_MEM  = 2'b01,
    Q_ALU  = 2'b10,
    Q_BR   = 2'b11
  } queue_t;

  // ctrl = {pry[1:0], queue[1:0], slot_valid}
  localparam int CTRL_VALID = 0;
  localparam int CTRL_QUEUE = 1;
  localparam int CTRL_PRY   = 3;
  localparam int CTRL_W     = 5;

  // Unknown opcodes fall back to R so every register field is passed on.
  function automatic imm_src_t format_of(input logic [6:0] opcode);
    imm_src_t fmt;
    case (opcode)
      OP_OP:                                             fmt = RT;
      OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_FENCE:   fmt = IT;
      OP_STORE:                                          fmt = ST;
      OP_BRANCH:                                         fmt = BT;
      OP_LUI, OP_AUIPC:                                  fmt = UT;
      OP_JAL:                                            fmt = JT;
      default:                                           fmt = RT;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_slot.sv
// Combinational decode of one instruction: format, immediate, register/func
// packing, issue queue and priority.
module decode_slot
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output logic [6:0]  uop,
  output logic [14:0] regs,
  output logic [9:0]  func,
  output logic [4:0]  ctrl,
  output logic [31:0] imm,
  output logic        is_branch
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_src_t   fmt;
  queue_t     queue;
  logic [1:0] pry;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    fmt       = format_of(opcode);
    uop       = opcode;
    regs      = '0;
    func      = '0;
    ctrl      = '0;
    imm       = '0;
    queue     = Q_NONE;
    pry       = 2'b00;
    is_branch = 1'b0;

    case (fmt)
      IT:      imm = {{20{instr[31]}}, instr[31:20]};
      ST:      imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      BT:      imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      UT:      imm = {instr[31:12], 12'd0};
      JT:      imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase

    // An invalid slot leaves regs, func and ctrl at zero.
    if (valid) begin
      case (fmt)
        RT:      regs = {rd, rs2, rs1};
        IT:      regs = {rd, 5'd0, rs1};
        ST, BT:  regs = {5'd0, rs2, rs1};
        default: regs = {rd, 10'd0};
      endcase

      func = {(fmt == RT) ? funct7 : 7'd0, funct3};

      if (opcode == OP_LOAD || opcode == OP_STORE)
        queue = Q_MEM;
      else if (opcode == OP_BRANCH || opcode == OP_JAL || opcode == OP_JALR)
        queue = Q_BR;
      else
        queue = Q_ALU;

      pry = (fmt == BT || fmt == JT) ? 2'b11 : 2'b00;

      ctrl[CTRL_VALID]      = 1'b1;
      ctrl[CTRL_QUEUE +: 2] = queue;
      ctrl[CTRL_PRY +: 2]   = pry;
      is_branch             = (queue == Q_BR);
    end
  end

endmodule

// File: rtl/decode_wide.sv
// Multi-slot decode stage: per-slot decode, branch tag allocation from a free
// pool, and a registered output bundle with resolve/kill handling.
module decode_wide
  import decode_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int WIDTH_BRM = 6
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [32*WIDTH-1:0]        i_instr,
  input  logic [WIDTH-1:0]           i_imask,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [7*WIDTH-1:0]         o_uop,
  output logic [15*WIDTH-1:0]        o_regs,
  output logic [10*WIDTH-1:0]        o_func,
  output logic [CTRL_W*WIDTH-1:0]    o_ctrl,
  output logic [32*WIDTH-1:0]        o_imm,
  output logic [WIDTH_BRM*WIDTH-1:0] o_brtag,
  output logic [WIDTH_BRM*WIDTH-1:0] o_brmask,
  input  logic [WIDTH_BRM-1:0]       i_br_free,
  input  logic [WIDTH_BRM-1:0]       i_kill_mask
);

  logic [7*WIDTH-1:0]         slot_uop;
  logic [15*WIDTH-1:0]        slot_regs;
  logic [10*WIDTH-1:0]        slot_func;
  logic [CTRL_W*WIDTH-1:0]    slot_ctrl;
  logic [32*WIDTH-1:0]        slot_imm;
  logic [WIDTH-1:0]           is_branch;

  logic [WIDTH_BRM-1:0]       live;
  logic [WIDTH_BRM-1:0]       free_bits;
  logic [WIDTH_BRM-1:0]       avail;
  logic [WIDTH_BRM-1:0]       alloc;
  logic [WIDTH_BRM*WIDTH-1:0] tag_flat;
  logic [WIDTH_BRM*WIDTH-1:0] mask_flat;
  logic [WIDTH-1:0]           kept_valid;
  int                         need;
  int                         free_cnt;
  logic                       accept;

  for (genvar g = 0; g < WIDTH; g++) begin : g_slot
    decode_slot u_slot (
      .instr     (i_instr[32*g +: 32]),
      .valid     (i_imask[g]),
      .uop       (slot_uop[7*g +: 7]),
      .regs      (slot_regs[15*g +: 15]),
      .func      (slot_func[10*g +: 10]),
      .ctrl      (slot_ctrl[CTRL_W*g +: CTRL_W]),
      .imm       (slot_imm[32*g +: 32]),
      .is_branch (is_branch[g])
    );
  end

  assign free_bits = ~live;

  // Branch slots take the lowest free tag in slot order; each slot's mask is
  // everything already live plus tags handed to older slots of this bundle.
  always_comb begin
    avail     = free_bits;
    alloc     = '0;
    tag_flat  = '0;
    mask_flat = '0;
    need      = 0;
    free_cnt  = 0;
    for (int b = 0; b < WIDTH_BRM; b++)
      free_cnt = free_cnt + int'(free_bits[b]);
    for (int i = 0; i < WIDTH; i++) begin
      mask_flat[WIDTH_BRM*i +: WIDTH_BRM] = live | alloc;
      if (is_branch[i]) begin
        tag_flat[WIDTH_BRM*i +: WIDTH_BRM] = avail & (-avail);
        avail = avail & ~(avail & (-avail));
        alloc = alloc | tag_flat[WIDTH_BRM*i +: WIDTH_BRM];
        need  = need + 1;
      end
    end
  end

  assign o_ready = (!o_valid || i_ready) && (free_cnt >= need) && (i_kill_mask == '0);
  assign accept  = i_en && o_ready;

  // A held slot survives a kill only if neither its own tag nor any older
  // branch it depends on is being squashed.
  always_comb begin
    kept_valid = '0;
    for (int i = 0; i < WIDTH; i++)
      kept_valid[i] = o_ctrl[CTRL_W*i + CTRL_VALID] &&
                      ((( o_brmask[WIDTH_BRM*i +: WIDTH_BRM] |
                          o_brtag[WIDTH_BRM*i +: WIDTH_BRM]) & i_kill_mask) == '0);
  end

  // Output bundle register and live tag pool. Freed bits are stripped from a
  // freshly loaded mask too, since those branches are already resolved.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      live     <= '0;
      o_valid  <= 1'b0;
      o_uop    <= '0;
      o_regs   <= '0;
      o_func   <= '0;
      o_ctrl   <= '0;
      o_imm    <= '0;
      o_brtag  <= '0;
      o_brmask <= '0;
    end else begin
      live <= (live & ~i_br_free & ~i_kill_mask) | (accept ? alloc : '0);
      if (accept) begin
        o_valid  <= 1'b1;
        o_uop    <= slot_uop;
        o_regs   <= slot_regs;
        o_func   <= slot_func;
        o_ctrl   <= slot_ctrl;
        o_imm    <= slot_imm;
        o_brtag  <= tag_flat;
        o_brmask <= mask_flat & {WIDTH{~i_br_free}};
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end else if (o_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          o_brmask[WIDTH_BRM*i +: WIDTH_BRM] <= o_brmask[WIDTH_BRM*i +: WIDTH_BRM] & ~i_br_free;
          if (i_kill_mask != '0)
            o_ctrl[CTRL_W*i + CTRL_VALID] <= kept_valid[i];
        end
        if (i_kill_mask != '0 && kept_valid == '0)
          o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_wide.sv
// Directed bench for decode_wide: single-instruction vector table plus
// hand-written handshake, allocation, kill and reset sequences.
module tb_decode_wide;

  localparam int WIDTH     = 2;
  localparam int WIDTH_BRM = 6;

  localparam logic [31:0] ADD = 32'h003100B3;
  localparam logic [31:0] LW  = 32'h0082A203;
  localparam logic [31:0] BEQ = 32'h00208863;

  logic                       clk;
  logic                       rst;
  logic                       en;
  logic [32*WIDTH-1:0]        instr;
  logic [WIDTH-1:0]           imask;
  logic                       o_ready;
  logic                       o_valid;
  logic                       ready;
  logic [7*WIDTH-1:0]         o_uop;
  logic [15*WIDTH-1:0]        o_regs;
  logic [10*WIDTH-1:0]        o_func;
  logic [5*WIDTH-1:0]         o_ctrl;
  logic [32*WIDTH-1:0]        o_imm;
  logic [WIDTH_BRM*WIDTH-1:0] o_brtag;
  logic [WIDTH_BRM*WIDTH-1:0] o_brmask;
  logic [WIDTH_BRM-1:0]       br_free;
  logic [WIDTH_BRM-1:0]       kill;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  uop;
    logic [14:0] regs;
    logic [9:0]  func;
    logic [4:0]  ctrl;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [11];

  decode_wide #(.WIDTH(WIDTH), .WIDTH_BRM(WIDTH_BRM)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_instr     (instr),
    .i_imask     (imask),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_uop       (o_uop),
    .o_regs      (o_regs),
    .o_func      (o_func),
    .o_ctrl      (o_ctrl),
    .o_imm       (o_imm),
    .o_brtag     (o_brtag),
    .o_brmask    (o_brmask),
    .i_br_free   (br_free),
    .i_kill_mask (kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic e, input logic [31:0] in0, input logic [31:0] in1,
                                input logic [1:0] m, input logic r,
                                input logic [5:0] f, input logic [5:0] k);
    en      = e;
    instr   = {in1, in0};
    imask   = m;
    ready   = r;
    br_free = f;
    kill    = k;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, " o_valid"},  64'(o_valid),  64'd0);
    check_output({tag, " o_uop"},    64'(o_uop),    64'd0);
    check_output({tag, " o_regs"},   64'(o_regs),   64'd0);
    check_output({tag, " o_func"},   64'(o_func),   64'd0);
    check_output({tag, " o_ctrl"},   64'(o_ctrl),   64'd0);
    check_output({tag, " o_imm"},    64'(o_imm),    64'd0);
    check_output({tag, " o_brtag"},  64'(o_brtag),  64'd0);
    check_output({tag, " o_brmask"}, 64'(o_brmask), 64'd0);
    check_output({tag, " o_ready"},  64'(o_ready),  64'd1);
  endtask

  initial begin
    vecs[0]  = '{32'h003100B3, 7'h33, 15'h0462, 10'h000, 5'h05, 32'h00000000}; // add x1,x2,x3
    vecs[1]  = '{32'h407302B3, 7'h33, 15'h14E6, 10'h100, 5'h05, 32'h00000000}; // sub x5,x6,x7
    vecs[2]  = '{32'h0082A203, 7'h03, 15'h1005, 10'h002, 5'h03, 32'h00000008}; // lw x4,8(x5)
    vecs[3]  = '{32'hFFF00093, 7'h13, 15'h0400, 10'h000, 5'h05, 32'hFFFFFFFF}; // addi x1,x0,-1
    vecs[4]  = '{32'hFE612E23, 7'h23, 15'h00C2, 10'h002, 5'h03, 32'hFFFFFFFC}; // sw x6,-4(x2)
    vecs[5]  = '{32'h00208863, 7'h63, 15'h0041, 10'h000, 5'h1F, 32'h00000010}; // beq x1,x2,16
    vecs[6]  = '{32'hFE419CE3, 7'h63, 15'h0083, 10'h001, 5'h1F, 32'hFFFFFFF8}; // bne x3,x4,-8
    vecs[7]  = '{32'h123453B7, 7'h37, 15'h1C00, 10'h005, 5'h05, 32'h12345000}; // lui x7,0x12345
    vecs[8]  = '{32'h001000EF, 7'h6F, 15'h0400, 10'h000, 5'h1F, 32'h00000800}; // jal x1,2048
    vecs[9]  = '{32'h00008067, 7'h67, 15'h0001, 10'h000, 5'h07, 32'h00000000}; // jalr x0,0(x1)
    vecs[10] = '{32'hFFFFF117, 7'h17, 15'h0800, 10'h007, 5'h05, 32'hFFFFF000}; // auipc x2,0xFFFFF

    // Reset.
    rst = 1'b1;
    apply_stimulus(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 6'd0, 6'd0);
    repeat (3) tick();
    rst = 1'b0;
    check_zero_outputs("reset");

    // add + lw bundle.
    apply_stimulus(1'b1, ADD, LW, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("addlw valid",      64'(o_valid),        64'd1);
    check_output("addlw ctrl0",      64'(o_ctrl[4:0]),    64'h05);
    check_output("addlw func0",      64'(o_func[9:0]),    64'h000);
    check_output("addlw regs0",      64'(o_regs[14:0]),   64'h0462);
    check_output("addlw ctrl1",      64'(o_ctrl[9:5]),    64'h03);
    check_output("addlw imm1",       64'(o_imm[63:32]),   64'd8);
    check_output("addlw brtag",      64'(o_brtag),        64'd0);

    // Two branches from an empty pool, then held for three cycles.
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b0, 6'd0, 6'd0);
    for (int c = 0; c < 4; c++) begin
      check_output("beq2 valid",  64'(o_valid),  64'd1);
      check_output("beq2 brtag",  64'(o_brtag),  64'b000010_000001);
      check_output("beq2 brmask", 64'(o_brmask), 64'b000001_000000);
      check_output("beq2 ctrl",   64'(o_ctrl),   64'b11111_11111);
      check_output("beq2 imm",    64'(o_imm),    {32'd16, 32'd16});
      if (c < 3) tick();
    end
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("drain valid", 64'(o_valid), 64'd0);

    // Reset while holding a bundle with live = 001111.
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("live4 brtag",  64'(o_brtag),  64'b001000_000100);
    check_output("live4 brmask", 64'(o_brmask), 64'b000111_000011);
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b0, 6'd0, 6'd0);
    tick();
    rst = 1'b1;
    tick();
    check_zero_outputs("midrst");
    rst = 1'b0;

    // Kill: slot1's own tag first, then slot0's.
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("postrst brtag", 64'(o_brtag), 64'b000010_000001);
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b0, 6'd0, 6'b000010);
    #1;
    check_output("kill ready", 64'(o_ready), 64'd0);
    tick();
    check_output("kill1 ctrl",  64'(o_ctrl),  64'b11110_11111);
    check_output("kill1 valid", 64'(o_valid), 64'd1);
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b0, 6'd0, 6'b000001);
    tick();
    check_output("kill2 ctrl",  64'(o_ctrl),  64'b11110_11110);
    check_output("kill2 valid", 64'(o_valid), 64'd0);
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("postkill brtag",  64'(o_brtag),  64'b000010_000001);
    check_output("postkill brmask", 64'(o_brmask), 64'b000001_000000);

    // Fill the pool to 111111, free bit 0, then starve and refill.
    tick();
    tick();
    check_output("fill brtag",  64'(o_brtag),  64'b100000_010000);
    check_output("fill brmask", 64'(o_brmask), 64'b011111_001111);
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b1, 6'b000001, 6'd0);
    tick();
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    #1;
    check_output("starve ready0", 64'(o_ready), 64'd0);
    tick();
    check_output("starve valid", 64'(o_valid), 64'd0);
    check_output("starve ready1", 64'(o_ready), 64'd0);
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'b000100, 6'd0);
    #1;
    check_output("free cycle ready", 64'(o_ready), 64'd0);
    tick();
    apply_stimulus(1'b1, BEQ, BEQ, 2'b11, 1'b1, 6'd0, 6'd0);
    #1;
    check_output("refill ready", 64'(o_ready), 64'd1);
    tick();
    check_output("refill valid",  64'(o_valid),  64'd1);
    check_output("refill brtag",  64'(o_brtag),  64'b000100_000001);
    check_output("refill brmask", 64'(o_brmask), 64'b111011_111010);
    apply_stimulus(1'b0, BEQ, BEQ, 2'b11, 1'b1, 6'b111111, 6'd0);
    tick();

    // Empty bundle is still accepted.
    apply_stimulus(1'b1, ADD, ADD, 2'b00, 1'b1, 6'd0, 6'd0);
    tick();
    check_output("empty valid", 64'(o_valid), 64'd1);
    check_output("empty ctrl",  64'(o_ctrl),  64'd0);
    check_output("empty regs",  64'(o_regs),  64'd0);
    check_output("empty func",  64'(o_func),  64'd0);

    // Single-instruction decode table in slot 0.
    for (int v = 0; v < 11; v++) begin
      apply_stimulus(1'b1, vecs[v].instr, ADD, 2'b01, 1'b1, 6'b111111, 6'd0);
      tick();
      check_output($sformatf("vec%0d valid", v), 64'(o_valid),       64'd1);
      check_output($sformatf("vec%0d uop", v),   64'(o_uop[6:0]),    64'(vecs[v].uop));
      check_output($sformatf("vec%0d regs", v),  64'(o_regs[14:0]),  64'(vecs[v].regs));
      check_output($sformatf("vec%0d func", v),  64'(o_func[9:0]),   64'(vecs[v].func));
      check_output($sformatf("vec%0d ctrl", v),  64'(o_ctrl[4:0]),   64'(vecs[v].ctrl));
      check_output($sformatf("vec%0d imm", v),   64'(o_imm[31:0]),   64'(vecs[v].imm));
      check_output($sformatf("vec%0d ctrl1", v), 64'(o_ctrl[9:5]),   64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
